wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered write requests (power of two, >=2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: ld_valid / ld_rd / ld_data  input  1/5/32  load-unit write request.
REQ-005 Port: ld_ready  output  1  load request accepted this cycle when ld_valid & ld_ready.
REQ-006 Port: alu_valid / alu_rd / alu_data  input  1/5/32  ALU write request.
REQ-007 Port: alu_ready  output  1  ALU request accepted this cycle when alu_valid & alu_ready.
REQ-008 Port: wb_hold  input  1  when 1, no entry is drained.
REQ-009 Port: rw / busW / reg_wr  output  5/32/1  register-file write port; rw drives the register file's rd with r_type tied 1.
REQ-010 Port: pending  output  32  bit r = 1 while any queued entry targets register r.
REQ-011 Port: full / empty  output  1/1  queue occupancy flags.

Function
REQ-012 Queue SHALL be FIFO; entries are {rd, data}; count range 0..DEPTH.
REQ-013 ld_ready SHALL = (count < DEPTH), based on registered count only.
REQ-014 alu_ready SHALL = (count < DEPTH-1) | ((count < DEPTH) & ~ld_valid); load wins the last slot.
REQ-015 When both are accepted in one cycle, the load entry SHALL be enqueued ahead of the ALU entry.
REQ-016 A same-cycle drain SHALL NOT raise ready; space freed by a pop is usable the next cycle.
REQ-017 Requests with rd = 5'd31 SHALL be accepted (handshake completes) and discarded; register 31 is not writable.
REQ-018 Each cycle with ~empty & ~wb_hold, the head SHALL be popped and presented as rw/busW with reg_wr=1 for that cycle.
REQ-019 reg_wr SHALL be 0 whenever empty or wb_hold; rw/busW hold their last value when reg_wr=0.
REQ-020 Latency SHALL be: accepted in cycle N into an empty queue -> reg_wr=1 in cycle N+1.
REQ-021 pending SHALL be computed combinationally from valid entries; bit 31 is always 0.
REQ-022 Pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-023 full SHALL = (count == DEPTH); empty SHALL = (count == 0).

Reset
REQ-024 On reset low, count, pointers, pending, reg_wr, rw and busW SHALL be 0, empty=1 and full=0, immediately and independent of clk.
REQ-025 Reset mid-operation SHALL discard all queued entries; no write is issued for them.
REQ-026 Stored data SHALL NOT require reset; only control state does.

Configuration
REQ-027 Macro WBQ_BYPASS_EN: when defined and empty & ~wb_hold, one accepted request (load priority) SHALL drive rw/busW/reg_wr combinationally in the same cycle and not be enqueued; a second same-cycle request is enqueued.
REQ-028 Without WBQ_BYPASS_EN, every request SHALL pass through the queue (REQ-020 latency).

Structure
REQ-029 The shared package SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 and the wb_entry_t {rd, data} type.
REQ-030 Storage and pointers SHALL be one sub-module, sync_fifo_n, parameterised by depth and entry width; arbitration, the r31 filter and the pending logic stay in wb_queue.

Verification
REQ-031 Reset release, ld rd=3 data=0xDEADBEEF in cycle 1 -> reg_wr=1, rw=3, busW=0xDEADBEEF in cycle 2; pending[3]=1 in cycle 2 only.
REQ-032 Both valid, count=3 -> ld accepted, alu_ready=0, full=1 next cycle; ALU is accepted after the next pop.
REQ-033 Both accepted (ld rd=5, alu rd=6) into empty queue -> writes to 5 then 6 on consecutive cycles.
REQ-034 alu rd=31 valid -> alu_ready=1, no enqueue, reg_wr stays 0, pending stays 0.
REQ-035 wb_hold=1 for 6 cycles with 4 entries queued -> full=1, no reg_wr; release -> 4 writes in order, then empty=1.
REQ-036 Reset asserted low with 3 entries queued -> empty=1, pending=0 without a clock edge; no writes after release.

Source files
------------

// File: rtl/wb_queue_pkg.sv
// Shared widths, the write-back entry type and a register one-hot helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    // Register 31 is not writable; requests aimed at it are swallowed.
    localparam logic [REG_ADDR_W-1:0] DISCARD_REG = 5'd31;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
        reg_onehot     = '0;
        reg_onehot[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo_n.sv
// Generic FIFO with two ordered write ports (a ahead of b) and one read port.
// Latency: a push is visible at head_o the cycle after the write edge.
// Backpressure: none internally; the caller must never push past DEPTH or pop when empty.
module sync_fifo_n #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_a_i,
    input  logic [WIDTH-1:0]             dat_a_i,
    input  logic                         push_b_i,
    input  logic [WIDTH-1:0]             dat_b_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [DEPTH-1:0][WIDTH-1:0]  mem_o,
    output logic [DEPTH-1:0]             vld_o,
    output logic [CW-1:0]                count_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PW-1:0]               wptr_q, wptr_d, wptr_b, rptr_q, rptr_d;
    logic [CW-1:0]               count_q, count_d;

    // Next pointers and count; port b lands right behind port a when both push.
    always_comb begin
        wptr_b  = wptr_q + PW'(push_a_i);
        wptr_d  = wptr_b + PW'(push_b_i);
        rptr_d  = rptr_q + PW'(pop_i);
        count_d = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);
    end

    // Entry storage carries no reset; validity comes from the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push_a_i) mem_q[wptr_q] <= dat_a_i;
        if (push_b_i) mem_q[wptr_b] <= dat_b_i;
    end

    // Pointer and occupancy state; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        vld_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld_o[i] = {1'b0, PW'(i) - rptr_q} < count_q;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign mem_o   = mem_q;
    assign count_o = count_q;

endmodule

// File: rtl/wb_queue.sv
// Write-back queue merging load and ALU results into one register-file write port.
// Latency: accept in cycle N -> reg_wr in N+1 (same cycle with WBQ_BYPASS_EN when empty).
// Backpressure: ready from registered count only; load wins the last free slot.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  ld_ready,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_ready,
    input  logic                  wb_hold,
    output logic [REG_ADDR_W-1:0] rw,
    output logic [DATA_W-1:0]     busW,
    output logic                  reg_wr,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  full,
    output logic                  empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t [DEPTH-1:0] fifo_mem;
    wb_entry_t             fifo_head;
    logic [DEPTH-1:0]      fifo_vld;
    logic [CW-1:0]         count;

    wb_entry_t             ld_ent, alu_ent, out_q, out_d;
    logic                  ld_keep, alu_keep, push_a, push_b, pop;
    logic [NUM_REGS-1:0]   pend_raw;

    assign ld_ent  = '{rd: ld_rd,  data: ld_data};
    assign alu_ent = '{rd: alu_rd, data: alu_data};

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign ld_ready  = (count < CW'(DEPTH));
    assign alu_ready = (count < CW'(DEPTH - 1)) | ((count < CW'(DEPTH)) & ~ld_valid);

    // Arbitration, r31 filtering and write-port selection.
    always_comb begin
        ld_keep  = ld_valid  & ld_ready  & (ld_rd  != DISCARD_REG);
        alu_keep = alu_valid & alu_ready & (alu_rd != DISCARD_REG);
        push_a   = ld_keep;
        push_b   = alu_keep;
        pop      = ~empty & ~wb_hold;
        reg_wr   = pop;
        out_d    = out_q;
        if (pop) out_d = fifo_head;
`ifdef WBQ_BYPASS_EN
        // Idle queue: the first kept request goes straight to the port instead.
        if (reset & empty & ~wb_hold) begin
            if (ld_keep) begin
                push_a = 1'b0;
                reg_wr = 1'b1;
                out_d  = ld_ent;
            end else if (alu_keep) begin
                push_b = 1'b0;
                reg_wr = 1'b1;
                out_d  = alu_ent;
            end
        end
`endif
    end

    // Hold the last written rd/data so the port is stable between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_q <= '0;
        else        out_q <= out_d;
    end

    assign rw   = out_d.rd;
    assign busW = out_d.data;

    // Scoreboard of registers with an outstanding queued write.
    always_comb begin
        pend_raw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i]) pend_raw = pend_raw | reg_onehot(fifo_mem[i].rd);
        end
    end

    assign pending = pend_raw & ~reg_onehot(DISCARD_REG);

    sync_fifo_n #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i    (clk),
        .rst_ni   (reset),
        .push_a_i (push_a),
        .dat_a_i  (ld_ent),
        .push_b_i (push_b),
        .dat_b_i  (alu_ent),
        .pop_i    (pop),
        .head_o   (fifo_head),
        .mem_o    (fifo_mem),
        .vld_o    (fifo_vld),
        .count_o  (count)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue against a queue-based reference model.
// Latency: checks combinational outputs mid-cycle, updates the model on each rising edge.
// Backpressure: model derives ready from its own occupancy.
module tb_wb_queue;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, alu_valid, wb_hold;
    logic [4:0]  ld_rd, alu_rd;
    logic [31:0] ld_data, alu_data;
    logic        ld_ready, alu_ready, reg_wr, full, empty;
    logic [4:0]  rw;
    logic [31:0] busW, pending;

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .wb_hold   (wb_hold),
        .rw        (rw),
        .busW      (busW),
        .reg_wr    (reg_wr),
        .pending   (pending),
        .full      (full),
        .empty     (empty)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of queued writes plus last written port value.
    logic [4:0]  qrd[$];
    logic [31:0] qd[$];
    logic [4:0]  last_rw;
    logic [31:0] last_bus;

    // Snapshot of DUT outputs from the most recent cycle.
    logic        s_ld_rdy, s_alu_rdy, s_full, s_empty, s_wr;
    logic [4:0]  s_rw;
    logic [31:0] s_bus, s_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                       input logic av, input logic [4:0] ard, input logic [31:0] add,
                       input logic hold);
        int          n;
        logic        e_ld_rdy, e_alu_rdy, e_wr;
        logic [4:0]  e_rw;
        logic [31:0] e_bus, e_pend;
        @(negedge clk);
        ld_valid = lv;  ld_rd = lrd;  ld_data = ldd;
        alu_valid = av; alu_rd = ard; alu_data = add;
        wb_hold = hold;
        #1;
        n         = qrd.size();
        e_ld_rdy  = (n < D);
        e_alu_rdy = (n < D - 1) || ((n < D) && !lv);
        e_wr      = (n > 0) && !hold;
        e_rw      = e_wr ? qrd[0] : last_rw;
        e_bus     = e_wr ? qd[0]  : last_bus;
        e_pend    = '0;
        foreach (qrd[i]) e_pend[qrd[i]] = 1'b1;
        s_ld_rdy = ld_ready; s_alu_rdy = alu_ready; s_full = full; s_empty = empty;
        s_wr = reg_wr; s_rw = rw; s_bus = busW; s_pend = pending;
        chk("ld_ready",  32'(s_ld_rdy),  32'(e_ld_rdy));
        chk("alu_ready", 32'(s_alu_rdy), 32'(e_alu_rdy));
        chk("full",      32'(s_full),    32'(n == D));
        chk("empty",     32'(s_empty),   32'(n == 0));
        chk("reg_wr",    32'(s_wr),      32'(e_wr));
        chk("rw",        32'(s_rw),      32'(e_rw));
        chk("busW",      s_bus,          e_bus);
        chk("pending",   s_pend,         e_pend);
        @(posedge clk);
        if (e_wr) begin
            last_rw  = qrd.pop_front();
            last_bus = qd.pop_front();
        end
        if (lv && e_ld_rdy && lrd != 5'd31) begin qrd.push_back(lrd); qd.push_back(ldd); end
        if (av && e_alu_rdy && ard != 5'd31) begin qrd.push_back(ard); qd.push_back(add); end
    endtask

    task automatic idle(input logic hold);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, hold);
    endtask

    initial begin
        reset = 1'b0; wb_hold = 1'b0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        last_rw = '0; last_bus = '0;

        // Reset state before any clock edge.
        #2;
        chk("rst_empty",   32'(empty),  32'd1);
        chk("rst_full",    32'(full),   32'd0);
        chk("rst_reg_wr",  32'(reg_wr), 32'd0);
        chk("rst_rw",      32'(rw),     32'd0);
        chk("rst_busW",    busW,        32'd0);
        chk("rst_pending", pending,     32'd0);
        #1 reset = 1'b1;

        // Single load: written the following cycle, pending only while queued.
        cyc(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("lat_c1_wr", 32'(s_wr), 32'd0);
        idle(1'b0);
        chk("lat_c2_wr",   32'(s_wr), 32'd1);
        chk("lat_c2_rw",   32'(s_rw), 32'd3);
        chk("lat_c2_bus",  s_bus,     32'hDEADBEEF);
        chk("lat_c2_pend", 32'(s_pend[3]), 32'd1);
        idle(1'b0);
        chk("lat_c3_pend", s_pend,    32'd0);
        chk("lat_c3_hold", 32'(s_rw), 32'd3);

        // ALU write to r31: handshake completes, nothing queued.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'h12345678, 1'b0);
        chk("r31_rdy", 32'(s_alu_rdy), 32'd1);
        idle(1'b0);
        chk("r31_wr",   32'(s_wr), 32'd0);
        chk("r31_pend", s_pend,    32'd0);

        // Both accepted into empty queue: load first, then ALU.
        cyc(1'b1, 5'd5, 32'h0000_0055, 1'b1, 5'd6, 32'h0000_0066, 1'b0);
        chk("both_alu_rdy", 32'(s_alu_rdy), 32'd1);
        idle(1'b0);
        chk("both_first",  32'(s_rw), 32'd5);
        idle(1'b0);
        chk("both_second", 32'(s_rw), 32'd6);
        chk("both_wr2",    32'(s_wr), 32'd1);

        // Fill under hold; load takes the last slot.
        cyc(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'hAA, 1'b1);
        chk("last_ld_rdy",  32'(s_ld_rdy),  32'd1);
        chk("last_alu_rdy", 32'(s_alu_rdy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAA, 1'b1);
            chk("hold_full", 32'(s_full), 32'd1);
            chk("hold_nowr", 32'(s_wr),   32'd0);
        end
        // Drain in the same cycle does not free the slot for that cycle.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAA, 1'b0);
        chk("drain_alu_rdy", 32'(s_alu_rdy), 32'd0);
        chk("drain_rw1",     32'(s_rw),      32'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAA, 1'b0);
        chk("after_pop_alu_rdy", 32'(s_alu_rdy), 32'd1);
        chk("drain_rw2",         32'(s_rw),      32'd2);
        idle(1'b0); chk("drain_rw3",  32'(s_rw), 32'd3);
        idle(1'b0); chk("drain_rw4",  32'(s_rw), 32'd4);
        idle(1'b0); chk("drain_rw10", 32'(s_rw), 32'd10);
        idle(1'b0); chk("drain_empty", 32'(s_empty), 32'd1);

        // Asynchronous reset with three entries queued.
        cyc(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1);
        ld_valid = 1'b0; alu_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_empty",   32'(empty),  32'd1);
        chk("arst_full",    32'(full),   32'd0);
        chk("arst_pending", pending,     32'd0);
        chk("arst_reg_wr",  32'(reg_wr), 32'd0);
        chk("arst_rw",      32'(rw),     32'd0);
        chk("arst_busW",    busW,        32'd0);
        qrd.delete(); qd.delete();
        last_rw = '0; last_bus = '0;
        @(negedge clk);
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            chk("post_rst_nowr", 32'(s_wr), 32'd0);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 500; k++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 3) == 0));
        end
        for (int k = 0; k < D + 1; k++) idle(1'b0);
        chk("final_empty", 32'(s_empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
